dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Sequences the single data-memory port between the CPU MEM stage (EM-stage outputs) and a DMA/debug requester.
//  Inserts WAIT_CYC memory wait states and drives STALL_M to freeze the pipeline during CPU accesses.
//  Guarantees DMA forward progress by granting DMA after at most MAX_CPU_RUN back-to-back CPU grants.
// PARAMETERS
//  WAIT_CYC     1   extra memory cycles per access; legal range 0..15; access phase lasts WAIT_CYC+1 cycles
//  MAX_CPU_RUN  4   consecutive CPU grants allowed while DMA_REQ is pending; legal range 1..15
//  AW           32  address width
//  DW           32  data width
// PORTS
//  CLK        in   1   clock, all state on posedge
//  RST        in   1   synchronous reset, active-high
//  DREQ_M     in   1   CPU data request, active-low (1 = idle)
//  DRW_M      in   1   CPU direction: 1 = write, 0 = read
//  ADDR_M     in   AW  CPU address (ALUOUT_M)
//  DI_M       in   DW  CPU write data (DOUT0_M)
//  STALL_M    out  1   freeze PC and pipeline registers
//  RDATA_M    out  DW  CPU read data, valid in CPU_DONE
//  DMA_REQ    in   1   DMA request, active-high; held until DMA_ACK
//  DMA_RW     in   1   DMA direction: 1 = write, 0 = read
//  DMA_ADDR   in   AW  DMA address
//  DMA_WDATA  in   DW  DMA write data
//  DMA_ACK    out  1   one-cycle completion pulse
//  DMA_RDATA  out  DW  DMA read data, valid with DMA_ACK
//  MEM_CSN    out  1   memory chip select, active-low
//  MEM_WEN    out  1   memory write enable, active-low
//  MEM_ADDR   out  AW  memory address
//  MEM_DI     out  DW  memory write data
//  MEM_DO     in   DW  memory read data, valid on the last access cycle
// BEHAVIOUR
//  Reset (RST=1 at posedge)
//   - state -> IDLE; wait and run counters -> 0.
//   - MEM_CSN=1, MEM_WEN=1; MEM_ADDR, MEM_DI, RDATA_M, DMA_RDATA -> 0; DMA_ACK=0.
//   - STALL_M is forced 0 while RST=1.
//   - Reset mid-access aborts immediately; no ACK is issued.
//  FSM states: IDLE, CPU_ACC, CPU_DONE, DMA_ACC, DMA_DONE.
//  IDLE arbitration
//   - DMA wins if DMA_REQ=1 and run counter == MAX_CPU_RUN.
//   - Otherwise CPU wins if DREQ_M=0.
//   - Otherwise DMA wins if DMA_REQ=1.
//   - With no request, stay in IDLE.
//  Grant
//   - Registers address, write data and direction into MEM_ADDR/MEM_DI; the winner's inputs are ignored afterwards.
//   - Wait counter clears.
//   - CPU grant: run counter +1 if DMA_REQ=1 (saturates at MAX_CPU_RUN); else cleared.
//   - DMA grant: run counter clears.
//  ACC states
//   - MEM_CSN=0; MEM_WEN=0 only for a write.
//   - Wait counter increments each cycle; on wait count == WAIT_CYC, go to *_DONE.
//   - Read data: MEM_DO is captured into RDATA_M or DMA_RDATA on that edge; on a write, the data registers hold.
//  DONE states (one cycle, then IDLE)
//   - MEM_CSN=1, MEM_WEN=1.
//   - CPU_DONE: STALL_M=0.
//   - DMA_DONE: DMA_ACK=1.
//  STALL_M (combinational)
//   - 1 when IDLE and DREQ_M=0, including when DMA wins arbitration.
//   - 1 in CPU_ACC, DMA_ACC and DMA_DONE when DREQ_M=0.
//   - 0 otherwise.
//   - CPU stall per access is WAIT_CYC+2 cycles from an idle grant. A request that arrives in CPU_DONE or DMA_DONE is arbitrated in the next IDLE cycle.
//  Request withdrawal
//   - DMA_REQ dropped mid-access: access still completes and ACK is still pulsed.
//   - DREQ_M cannot drop while STALL_M=1, because the EM register is frozen.
//  Simultaneous requests with run counter < MAX_CPU_RUN: CPU first, DMA next.
// TESTING
//  WAIT_CYC=1, CPU read of 0x40 (MEM_DO=0xDEADBEEF) -> STALL_M high 3 cycles, CSN low 2 cycles, RDATA_M=0xDEADBEEF in CPU_DONE.
//  CPU write of 0x1234 to 0x80 -> MEM_WEN low exactly 2 cycles with MEM_ADDR=0x80, MEM_DI=0x1234; RDATA_M unchanged.
//  DMA read of 0x10 with CPU idle -> DMA_ACK one pulse 3 cycles after request, DMA_RDATA=MEM_DO; STALL_M stays 0.
//  DMA_REQ and DREQ_M held continuously, MAX_CPU_RUN=4 -> grant order CPU x4, DMA, CPU x4, DMA...; no DMA wait exceeds 4 CPU accesses.
//  RST asserted during DMA_ACC -> next cycle IDLE, CSN=WEN=1, no DMA_ACK, counters 0.
//  WAIT_CYC=0 back-to-back CPU reads -> CSN low 1 cycle per access, STALL_M 2 cycles per access, addresses in order.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single data-memory port between the CPU MEM stage and a DMA/debug
// requester. Each access holds the port for WAIT_CYC+1 access cycles and then
// one completion cycle. The CPU pipeline is frozen while its request is
// outstanding. DMA is served after at most MAX_CPU_RUN back-to-back CPU grants.
module dmem_arbiter #(
  parameter int WAIT_CYC    = 1,
  parameter int MAX_CPU_RUN = 4,
  parameter int AW          = 32,
  parameter int DW          = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          DREQ_M,
  input  logic          DRW_M,
  input  logic [AW-1:0] ADDR_M,
  input  logic [DW-1:0] DI_M,
  output logic          STALL_M,
  output logic [DW-1:0] RDATA_M,
  input  logic          DMA_REQ,
  input  logic          DMA_RW,
  input  logic [AW-1:0] DMA_ADDR,
  input  logic [DW-1:0] DMA_WDATA,
  output logic          DMA_ACK,
  output logic [DW-1:0] DMA_RDATA,
  output logic          MEM_CSN,
  output logic          MEM_WEN,
  output logic [AW-1:0] MEM_ADDR,
  output logic [DW-1:0] MEM_DI,
  input  logic [DW-1:0] MEM_DO
);

  typedef enum logic [2:0] {
    IDLE,
    CPU_ACC,
    CPU_DONE,
    DMA_ACC,
    DMA_DONE
  } state_t;

  // Both counters fit in 4 bits because both parameters are limited to 0..15.
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYC);
  localparam logic [3:0] RUN_MAX   = 4'(MAX_CPU_RUN);

  state_t        r_state;
  logic [3:0]    r_wait;
  logic [3:0]    r_run;
  logic          r_we;

  logic          w_cpu_req;
  logic          w_grant_cpu;
  logic          w_grant_dma;
  logic          w_g_we;
  logic [AW-1:0] w_g_addr;
  logic [DW-1:0] w_g_data;

  assign w_cpu_req = ~DREQ_M;

  // Arbitration in IDLE: a starved DMA first, then the CPU, then any DMA.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    w_grant_cpu = 1'b0;
    w_grant_dma = 1'b0;
    if (r_state == IDLE) begin
      if (DMA_REQ && (r_run == RUN_MAX)) begin
        w_grant_dma = 1'b1;
      end else if (w_cpu_req) begin
        w_grant_cpu = 1'b1;
      end else if (DMA_REQ) begin
        w_grant_dma = 1'b1;
      end
    end
  end

  // The winner's request is selected here and captured at the grant edge.
  assign w_g_we   = w_grant_dma ? DMA_RW    : DRW_M;
  assign w_g_addr = w_grant_dma ? DMA_ADDR  : ADDR_M;
  assign w_g_data = w_grant_dma ? DMA_WDATA : DI_M;

  // Pipeline freeze: a CPU request is pending and it is not in its own completion cycle.
  always_comb begin
    STALL_M = 1'b0;
    if (!RST && w_cpu_req && (r_state != CPU_DONE)) begin
      STALL_M = 1'b1;
    end
  end

  // Access sequencer: grant, wait-state count, read-data capture, completion.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (RST) begin
      r_state   <= IDLE;
      r_wait    <= '0;
      r_run     <= '0;
      r_we      <= 1'b0;
      MEM_CSN   <= 1'b1;
      MEM_WEN   <= 1'b1;
      MEM_ADDR  <= '0;
      MEM_DI    <= '0;
      RDATA_M   <= '0;
      DMA_RDATA <= '0;
      DMA_ACK   <= 1'b0;
    end else begin
      DMA_ACK <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_cpu || w_grant_dma) begin
            r_state  <= w_grant_dma ? DMA_ACC : CPU_ACC;
            r_wait   <= '0;
            r_we     <= w_g_we;
            MEM_ADDR <= w_g_addr;
            MEM_DI   <= w_g_data;
            MEM_CSN  <= 1'b0;
            MEM_WEN  <= ~w_g_we;
            // The run only grows while DMA is actually waiting behind the CPU.
            if (w_grant_dma || !DMA_REQ) begin
              r_run <= '0;
            end else if (r_run != RUN_MAX) begin
              r_run <= r_run + 4'd1;
            end
          end
        end
        CPU_ACC, DMA_ACC: begin
          r_wait <= r_wait + 4'd1;
          if (r_wait == WAIT_LAST) begin
            MEM_CSN <= 1'b1;
            MEM_WEN <= 1'b1;
            if (r_state == CPU_ACC) begin
              r_state <= CPU_DONE;
              if (!r_we) begin
                RDATA_M <= MEM_DO;
              end
            end else begin
              r_state <= DMA_DONE;
              DMA_ACK <= 1'b1;
              if (!r_we) begin
                DMA_RDATA <= MEM_DO;
              end
            end
          end
        end
        CPU_DONE, DMA_DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios followed by randomized CPU and
// DMA traffic, all compared cycle by cycle against a transaction-level model of
// the memory port. A second instance with zero wait states covers back-to-back
// single-cycle accesses.
module tb_dmem_arbiter;

  localparam int WAIT_CYC = 1;
  localparam int MAX_RUN  = 4;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST, DREQ_M, DRW_M, DMA_REQ, DMA_RW;
  logic [31:0] ADDR_M, DI_M, DMA_ADDR, DMA_WDATA;
  logic        STALL_M, DMA_ACK, MEM_CSN, MEM_WEN;
  logic [31:0] RDATA_M, DMA_RDATA, MEM_ADDR, MEM_DI, MEM_DO;
  logic        STALL_M_z, DMA_ACK_z, MEM_CSN_z, MEM_WEN_z;
  logic [31:0] RDATA_M_z, DMA_RDATA_z, MEM_ADDR_z, MEM_DI_z, MEM_DO_z;

  // Memory contents are a fixed function of the address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  assign MEM_DO   = mem_fn(MEM_ADDR);
  assign MEM_DO_z = mem_fn(MEM_ADDR_z);

  dmem_arbiter #(.WAIT_CYC(WAIT_CYC), .MAX_CPU_RUN(MAX_RUN), .AW(32), .DW(32)) u_dut (
    .CLK(CLK), .RST(RST), .DREQ_M(DREQ_M), .DRW_M(DRW_M), .ADDR_M(ADDR_M), .DI_M(DI_M),
    .STALL_M(STALL_M), .RDATA_M(RDATA_M), .DMA_REQ(DMA_REQ), .DMA_RW(DMA_RW),
    .DMA_ADDR(DMA_ADDR), .DMA_WDATA(DMA_WDATA), .DMA_ACK(DMA_ACK), .DMA_RDATA(DMA_RDATA),
    .MEM_CSN(MEM_CSN), .MEM_WEN(MEM_WEN), .MEM_ADDR(MEM_ADDR), .MEM_DI(MEM_DI), .MEM_DO(MEM_DO)
  );

  dmem_arbiter #(.WAIT_CYC(0), .MAX_CPU_RUN(MAX_RUN), .AW(32), .DW(32)) u_dut_z (
    .CLK(CLK), .RST(RST), .DREQ_M(DREQ_M), .DRW_M(DRW_M), .ADDR_M(ADDR_M), .DI_M(DI_M),
    .STALL_M(STALL_M_z), .RDATA_M(RDATA_M_z), .DMA_REQ(DMA_REQ), .DMA_RW(DMA_RW),
    .DMA_ADDR(DMA_ADDR), .DMA_WDATA(DMA_WDATA), .DMA_ACK(DMA_ACK_z), .DMA_RDATA(DMA_RDATA_z),
    .MEM_CSN(MEM_CSN_z), .MEM_WEN(MEM_WEN_z), .MEM_ADDR(MEM_ADDR_z), .MEM_DI(MEM_DI_z), .MEM_DO(MEM_DO_z)
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Port model: m_left counts the cycles the port stays busy (access phase
  // while >= 2, completion cycle when 1, free when 0).
  int          m_left;
  int          m_run;
  bit          m_dma;
  bit          m_we;
  logic [31:0] m_addr, m_di, m_rdata, m_drdata;
  bit          prev_stall, prev_ack, prev_rst;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_stall();
    return !RST && !DREQ_M && (m_left == 0 || m_left >= 2 || m_dma);
  endfunction

  task automatic grant(input bit dma);
    m_dma  = dma;
    m_left = WAIT_CYC + 2;
    m_we   = dma ? DMA_RW : DRW_M;
    m_addr = dma ? DMA_ADDR : ADDR_M;
    m_di   = dma ? DMA_WDATA : DI_M;
    if (dma || !DMA_REQ) m_run = 0;
    else m_run = (m_run < MAX_RUN) ? m_run + 1 : MAX_RUN;
  endtask

  task automatic model_edge();
    if (RST) begin
      m_left = 0; m_run = 0; m_dma = 0; m_we = 0;
      m_addr = '0; m_di = '0; m_rdata = '0; m_drdata = '0;
    end else if (m_left == 0) begin
      if (DMA_REQ && m_run == MAX_RUN) grant(1'b1);
      else if (!DREQ_M) grant(1'b0);
      else if (DMA_REQ) grant(1'b1);
    end else begin
      if (m_left == 2 && !m_we) begin
        if (m_dma) m_drdata = mem_fn(m_addr);
        else m_rdata = mem_fn(m_addr);
      end
      m_left--;
    end
  endtask

  task automatic cmp_all();
    check("stall",     32'(STALL_M),   32'(exp_stall()));
    check("mem_csn",   32'(MEM_CSN),   32'(!(m_left >= 2)));
    check("mem_wen",   32'(MEM_WEN),   32'(!(m_left >= 2 && m_we)));
    check("mem_addr",  MEM_ADDR,       m_addr);
    check("mem_di",    MEM_DI,         m_di);
    check("rdata_m",   RDATA_M,        m_rdata);
    check("dma_ack",   32'(DMA_ACK),   32'(m_left == 1 && m_dma));
    check("dma_rdata", DMA_RDATA,      m_drdata);
  endtask

  // One clock: remember what the requesters saw, advance the model, settle.
  task automatic tick();
    prev_stall = exp_stall();
    prev_ack   = (m_left == 1 && m_dma);
    prev_rst   = RST;
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic cpu_access(input logic [31:0] a, input logic w, input logic [31:0] d,
                            output int n_stall, output int n_csn, output int n_wen,
                            output logic [31:0] rd_done, output logic [31:0] wen_addr,
                            output logic [31:0] wen_di);
    bit done;
    DREQ_M = 1'b0; DRW_M = w; ADDR_M = a; DI_M = d;
    n_stall = 0; n_csn = 0; n_wen = 0; done = 0;
    rd_done = '0; wen_addr = '0; wen_di = '0;
    for (int k = 0; k < 64 && !done; k++) begin
      #1;
      cmp_all();
      if (STALL_M) n_stall++;
      if (!MEM_CSN) n_csn++;
      if (!MEM_WEN) begin
        n_wen++;
        wen_addr = MEM_ADDR;
        wen_di   = MEM_DI;
      end
      if (!STALL_M) begin
        done    = 1;
        rd_done = RDATA_M;
      end
      tick();
    end
    check("cpu_done_seen", 32'(done), 32'd1);
    DREQ_M = 1'b1;
  endtask

  initial begin
    int          ns, nc, nw, n_ack, ack_at, ng, dma_st;
    logic [31:0] rd, wa, wd, got, za;
    logic        prev_csn;
    bit          cpu_nx, dma_nx, zdone;

    // ---- reset ----
    RST = 1'b1; DREQ_M = 1'b1; DRW_M = 1'b0; ADDR_M = '0; DI_M = '0;
    DMA_REQ = 1'b0; DMA_RW = 1'b0; DMA_ADDR = '0; DMA_WDATA = '0;
    tick();
    DREQ_M = 1'b0;
    #1;
    check("stall_forced_in_reset", 32'(STALL_M), 32'd0);
    tick();
    RST = 1'b0; DREQ_M = 1'b1;
    #1;
    check("reset_csn",   32'(MEM_CSN), 32'd1);
    check("reset_wen",   32'(MEM_WEN), 32'd1);
    check("reset_ack",   32'(DMA_ACK), 32'd0);
    check("reset_addr",  MEM_ADDR,     32'd0);
    check("reset_rdata", RDATA_M,      32'd0);
    cmp_all();
    tick();

    // ---- CPU read of 0x40 ----
    cpu_access(32'h40, 1'b0, 32'hAAAA_5555, ns, nc, nw, rd, wa, wd);
    check("cpu_rd_stall_cycles", ns, 3);
    check("cpu_rd_csn_cycles",   nc, 2);
    check("cpu_rd_wen_cycles",   nw, 0);
    check("cpu_rd_data",         rd, 32'hDEAD_BEEF);

    // ---- CPU write of 0x1234 to 0x80 ----
    cpu_access(32'h80, 1'b1, 32'h1234, ns, nc, nw, rd, wa, wd);
    check("cpu_wr_stall_cycles", ns, 3);
    check("cpu_wr_wen_cycles",   nw, 2);
    check("cpu_wr_addr",         wa, 32'h80);
    check("cpu_wr_data",         wd, 32'h1234);
    check("cpu_wr_rdata_held",   rd, 32'hDEAD_BEEF);

    // ---- DMA read of 0x10, CPU idle ----
    DMA_REQ = 1'b1; DMA_RW = 1'b0; DMA_ADDR = 32'h10; DMA_WDATA = 32'hFFFF;
    ack_at = -1; n_ack = 0; ns = 0; got = '0;
    for (int k = 0; k < 8; k++) begin
      #1;
      cmp_all();
      if (STALL_M) ns++;
      if (DMA_ACK) begin
        n_ack++;
        if (ack_at < 0) begin
          ack_at = k;
          got    = DMA_RDATA;
        end
      end
      tick();
      if (ack_at >= 0) DMA_REQ = 1'b0;
    end
    check("dma_ack_latency", ack_at, 3);
    check("dma_ack_pulses",  n_ack,  1);
    check("dma_rdata",       got,    mem_fn(32'h10));
    check("dma_no_stall",    ns,     0);

    // ---- reset during DMA_ACC ----
    DMA_REQ = 1'b1; DMA_RW = 1'b1; DMA_ADDR = 32'h30; DMA_WDATA = 32'h5555;
    #1; cmp_all(); tick();
    #1; cmp_all();
    check("rst_mid_in_acc", 32'(MEM_CSN), 32'd0);
    RST = 1'b1; DREQ_M = 1'b0;
    #1;
    check("rst_mid_stall_forced", 32'(STALL_M), 32'd0);
    cmp_all();
    tick();
    RST = 1'b0; DMA_REQ = 1'b0; DREQ_M = 1'b1;
    #1;
    check("rst_mid_csn",  32'(MEM_CSN), 32'd1);
    check("rst_mid_wen",  32'(MEM_WEN), 32'd1);
    check("rst_mid_addr", MEM_ADDR,     32'd0);
    n_ack = 0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) #1;
      cmp_all();
      if (DMA_ACK) n_ack++;
      tick();
    end
    check("rst_mid_no_ack", n_ack, 0);
    cpu_access(32'h44, 1'b0, 32'h0, ns, nc, nw, rd, wa, wd);
    check("post_rst_stall_cycles", ns, 3);
    check("post_rst_csn_cycles",   nc, 2);

    // ---- fairness: both requesters held continuously ----
    DREQ_M = 1'b0; DRW_M = 1'b0; ADDR_M = 32'h1000_0000; DI_M = 32'h0;
    DMA_REQ = 1'b1; DMA_RW = 1'b0; DMA_ADDR = 32'h2000_0000;
    ng = 0; prev_csn = 1'b1;
    for (int k = 0; k < 200 && ng < 10; k++) begin
      #1;
      cmp_all();
      if (prev_csn && !MEM_CSN) begin
        check("grant_order", 32'(MEM_ADDR[29]), 32'((ng % 5) == 4));
        ng++;
      end
      prev_csn = MEM_CSN;
      cpu_nx   = !STALL_M;
      dma_nx   = DMA_ACK;
      tick();
      if (cpu_nx) ADDR_M = ADDR_M + 32'd4;
      if (dma_nx) DMA_ADDR = DMA_ADDR + 32'd4;
    end
    check("grant_count", ng, 10);

    // ---- randomized traffic ----
    dma_st = DMA_REQ ? 1 : 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      RST = ($urandom_range(0, 399) == 0);
      if (!prev_stall) begin
        DREQ_M = ($urandom_range(0, 2) == 0);
        DRW_M  = 1'($urandom_range(0, 1));
        ADDR_M = 32'($urandom_range(0, 63)) << 2;
        DI_M   = $urandom;
      end
      if (prev_ack || prev_rst) dma_st = 0;
      if (dma_st == 0) begin
        if ($urandom_range(0, 3) == 0) begin
          dma_st    = 1;
          DMA_REQ   = 1'b1;
          DMA_RW    = 1'($urandom_range(0, 1));
          DMA_ADDR  = 32'($urandom_range(0, 63)) << 2;
          DMA_WDATA = $urandom;
        end else begin
          DMA_REQ = 1'b0;
        end
      end else if (dma_st == 1 && m_left >= 2 && m_dma && $urandom_range(0, 5) == 0) begin
        dma_st  = 2;
        DMA_REQ = 1'b0;
      end
      if (m_left >= 1 && m_dma) begin
        DMA_ADDR  = $urandom;
        DMA_WDATA = $urandom;
        DMA_RW    = 1'($urandom_range(0, 1));
      end
      #1;
      cmp_all();
      tick();
    end

    // ---- zero wait states, back-to-back CPU reads (second instance) ----
    RST = 1'b1; DREQ_M = 1'b1; DMA_REQ = 1'b0;
    tick(); tick();
    RST = 1'b0; DRW_M = 1'b0; DI_M = 32'h0;
    for (int a = 0; a < 6; a++) begin
      ADDR_M = 32'h300 + 32'(a) * 32'd8;
      DREQ_M = 1'b0;
      ns = 0; nc = 0; zdone = 0; za = '0;
      for (int k = 0; k < 16 && !zdone; k++) begin
        #1;
        if (STALL_M_z) ns++;
        if (!MEM_CSN_z) begin
          nc++;
          za = MEM_ADDR_z;
        end
        check("z_no_ack", 32'(DMA_ACK_z), 32'd0);
        check("z_no_wen", 32'(MEM_WEN_z), 32'd1);
        if (!STALL_M_z) begin
          zdone = 1;
          check("z_rdata",    RDATA_M_z,   mem_fn(ADDR_M));
          check("z_mem_di",   MEM_DI_z,    32'h0);
          check("z_dma_data", DMA_RDATA_z, 32'h0);
        end
        tick();
      end
      check("z_done_seen",    32'(zdone), 32'd1);
      check("z_stall_cycles", ns, 2);
      check("z_csn_cycles",   nc, 1);
      check("z_addr_order",   za, 32'h300 + 32'(a) * 32'd8);
    end
    DREQ_M = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
